bram_responder: RTL and testbench

- On-chip responder for the data-memory request bus (enable/addr/write/write_data/data_width → read_data/ready).
- This is the same bus the data-memory unit drives towards the SDRAM controller. This block answers it from block RAM, so the core and datamem run without external SDRAM (small builds, fast simulation).
- Emulates the SDRAM controller's timing: a post-reset init phase, then a programmable access latency.

---
 rtl/bram_resp_pkg.sv | 44 ++++
 rtl/bram_responder_if.sv | 15 +
 rtl/bram_resp_mem.sv | 24 ++
 rtl/bram_responder.sv | 129 ++++++++++++
 tb/tb_bram_responder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/bram_resp_pkg.sv
// Shared encodings and byte-lane helpers for the data-memory request bus.
// Also usable by the datamem unit that drives the same bus.
package bram_resp_pkg;

   localparam logic [1:0] DW_BYTE = 2'b00;
   localparam logic [1:0] DW_HALF = 2'b01;
   localparam logic [1:0] DW_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_WAIT   = 3'd2,
      ST_ACCESS = 3'd3,
      ST_FETCH  = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   // Byte enables for a store; width code 2'b11 behaves as a word.
   function automatic logic [3:0] lane_be(input logic [1:0] dw, input logic [1:0] lo);
      case (dw)
         DW_BYTE: lane_be = 4'b0001 << lo;
         DW_HALF: lane_be = lo[1] ? 4'b1100 : 4'b0011;
         default: lane_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] dw, input logic [31:0] wd);
      case (dw)
         DW_BYTE: lane_wdata = {4{wd[7:0]}};
         DW_HALF: lane_wdata = {2{wd[15:0]}};
         default: lane_wdata = wd;
      endcase
   endfunction

   function automatic logic [31:0] lane_extract(input logic [1:0] dw, input logic [1:0] lo,
                                                input logic [31:0] word);
      case (dw)
         DW_BYTE: lane_extract = {24'b0, word[{lo, 3'b000} +: 8]};
         DW_HALF: lane_extract = lo[1] ? {16'b0, word[31:16]} : {16'b0, word[15:0]};
         default: lane_extract = word;
      endcase
   endfunction

endpackage

// File: rtl/bram_responder_if.sv
// Data-memory request bus: initiator (master) drives the request, responder (slave) answers.
interface bram_responder_if;
   logic        enable;
   logic [23:0] addr;
   logic        write;
   logic [31:0] write_data;
   logic [1:0]  data_width;
   logic [31:0] read_data;
   logic        ready;

   modport master (output enable, addr, write, write_data, data_width,
                   input  read_data, ready);
   modport slave  (input  enable, addr, write, write_data, data_width,
                   output read_data, ready);
endinterface

// File: rtl/bram_resp_mem.sv
// Single-port 32-bit block RAM with per-byte write enables and a registered read port.
module bram_resp_mem #(
   parameter int ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic [3:0]        we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [2**ADDR_W];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 4; i++) begin
         if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_responder.sv
// Block-RAM stand-in for the SDRAM controller: init phase, programmable latency, byte lanes.
// Optional macro BRAM_RESPONDER_ZERO_FILL_EN: INIT clears every RAM word instead of counting INIT_CYCLES.
module bram_responder
   import bram_resp_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int LATENCY     = 2,
   parameter int INIT_CYCLES = 16
) (
   input logic             clk,
   input logic             rst,
   bram_responder_if.slave bus
);

   localparam int DEPTH = 2**ADDR_W;
`ifdef BRAM_RESPONDER_ZERO_FILL_EN
   localparam logic [31:0] INIT_LAST = 32'(DEPTH - 1);
`else
   localparam logic [31:0] INIT_LAST = (INIT_CYCLES > 0) ? 32'(INIT_CYCLES - 1) : 32'd0;
`endif
   localparam logic [31:0] LAT_LAST = (LATENCY > 0) ? 32'(LATENCY - 1) : 32'd0;

   state_e              state_q, state_d;
   logic [31:0]         cnt_q, cnt_d;
   logic [ADDR_W+1:0]   addr_q;
   logic                write_q;
   logic [31:0]         wdata_q;
   logic [1:0]          dw_q;
   logic [31:0]         rdata_q, rdata_d;
   logic                accept;
   logic [3:0]          mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [31:0]         mem_wdata;
   logic [31:0]         mem_rdata;
   logic                unused_addr_hi;

   // Upper address bits alias onto the RAM and are deliberately dropped.
   assign unused_addr_hi = ^bus.addr;
   assign accept = (state_q == ST_IDLE) && bus.enable;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            if (cnt_q >= INIT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_IDLE: begin
            if (bus.enable) begin
               cnt_d   = '0;
               state_d = (LATENCY > 0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            if (cnt_q >= LAT_LAST) state_d = ST_ACCESS;
            else                   cnt_d   = cnt_q + 32'd1;
         end
         ST_ACCESS: state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DONE;
         // A held enable parks here so one request never issues twice.
         ST_DONE:   if (!bus.enable) state_d = ST_IDLE;
         default:   state_d = ST_INIT;
      endcase
   end

   always_comb begin
      mem_we    = '0;
      mem_addr  = addr_q[ADDR_W+1:2];
      mem_wdata = lane_wdata(dw_q, wdata_q);
      if (state_q == ST_ACCESS && write_q) mem_we = lane_be(dw_q, addr_q[1:0]);
`ifdef BRAM_RESPONDER_ZERO_FILL_EN
      if (state_q == ST_INIT) begin
         mem_we    = 4'hF;
         mem_addr  = cnt_q[ADDR_W-1:0];
         mem_wdata = '0;
      end
`endif
   end

   always_comb begin
      rdata_d = rdata_q;
      if (state_q == ST_FETCH && !write_q) rdata_d = lane_extract(dw_q, addr_q[1:0], mem_rdata);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         dw_q    <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= bus.addr[ADDR_W+1:0];
            write_q <= bus.write;
            wdata_q <= bus.write_data;
            dw_q    <= bus.data_width;
         end
         rdata_q <= rdata_d;
      end
   end

   assign bus.ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign bus.read_data = rdata_q;

   bram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (mem_wdata),
      .rdata_o (mem_rdata)
   );

endmodule

// File: tb/tb_bram_responder.sv
// Randomized bench for bram_responder against a byte-addressed memory model with transaction-level timing.
module tb_bram_responder;
   import bram_resp_pkg::*;

   localparam int LAT      = 2;
   localparam int INIT_CYC = 16;
`ifdef BRAM_RESPONDER_ZERO_FILL_EN
   localparam int INIT_LEN = 1024;
   localparam bit ZF       = 1'b1;
`else
   localparam int INIT_LEN = INIT_CYC;
   localparam bit ZF       = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bram_responder_if bus ();
   bram_responder_if bus0 ();

   bram_responder #(.ADDR_W(10), .LATENCY(LAT), .INIT_CYCLES(INIT_CYC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   bram_responder #(.ADDR_W(10), .LATENCY(0), .INIT_CYCLES(4)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   int          total = 0;
   int          bad   = 0;
   bit          chk_en = 1'b0;
   logic        exp_ready = 1'b0;
   logic [31:0] exp_rd = '0;
   logic [7:0]  mbyte [4096];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int nbytes(input logic [1:0] dw);
      if (dw == DW_BYTE) return 1;
      if (dw == DW_HALF) return 2;
      return 4;
   endfunction

   // The RAM holds 4096 bytes; higher address bits wrap around.
   function automatic int base_of(input logic [23:0] a, input logic [1:0] dw);
      int n = nbytes(dw);
      return ((int'(a) % 4096) / n) * n;
   endfunction

   function automatic logic [31:0] model_load(input logic [23:0] a, input logic [1:0] dw);
      logic [31:0] v = '0;
      int b = base_of(a, dw);
      for (int k = 0; k < nbytes(dw); k++) v[8*k +: 8] = mbyte[b + k];
      return v;
   endfunction

   task automatic model_store(input logic [23:0] a, input logic [31:0] wd, input logic [1:0] dw);
      int b = base_of(a, dw);
      for (int k = 0; k < nbytes(dw); k++) mbyte[b + k] = wd[8*k +: 8];
   endtask

   // Caller is at a negedge; returns at a negedge with the DUT back in IDLE.
   task automatic xact(input logic [23:0] a, input logic w, input logic [31:0] wd,
                       input logic [1:0] dw, input int hold);
      logic [31:0] ld;
      if (bus.ready !== 1'b1) check("idle_before_req", {31'b0, bus.ready}, 32'd1);
      bus.enable = 1'b1; bus.addr = a; bus.write = w; bus.write_data = wd; bus.data_width = dw;
      ld = model_load(a, dw);
      @(posedge clk); #1;
      exp_ready = 1'b0;
      if (w) model_store(a, wd, dw);
      for (int i = 0; i < LAT + 2; i++) begin
         @(negedge clk);
         bus.addr = 24'($urandom); bus.write = 1'($urandom);
         bus.write_data = $urandom; bus.data_width = 2'($urandom);
         @(posedge clk); #1;
         if (i == LAT + 1) begin
            exp_ready = 1'b1;
            if (!w) exp_rd = ld;
         end
      end
      repeat (hold) @(posedge clk);
      @(negedge clk);
      bus.enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Releases reset and tracks INIT; optionally pokes store requests that must be ignored.
   task automatic init_seq(input bit pulse);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      if (ZF) for (int i = 0; i < 4096; i++) mbyte[i] = 8'h00;
      for (int i = 0; i < INIT_LEN; i++) begin
         @(posedge clk); #1;
         if (i == INIT_LEN - 1) exp_ready = 1'b1;
         if (pulse && i < INIT_LEN - 3) begin
            bus.enable = 1'((i % 2)); bus.write = 1'b1; bus.addr = 24'h000100;
            bus.write_data = 32'hFFFF_FFFF; bus.data_width = DW_WORD;
         end else begin
            bus.enable = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.enable = 1'b0; bus.addr = '0; bus.write = 1'b0; bus.write_data = '0; bus.data_width = DW_WORD;
      bus0.enable = 1'b0; bus0.addr = '0; bus0.write = 1'b0; bus0.write_data = '0; bus0.data_width = DW_WORD;
      for (int i = 0; i < 4096; i++) mbyte[i] = 8'hxx;

      fork
         forever begin
            @(negedge clk);
            if (chk_en) begin
               check("ready", {31'b0, bus.ready}, {31'b0, exp_ready});
               check("read_data", bus.read_data, exp_rd);
            end
         end
      join_none

      #3 rst = 1'b0;
      #1;
      chk_en = 1'b1;
      check("rst_ready", {31'b0, bus.ready}, 32'd0);
      check("rst_rdata", bus.read_data, 32'd0);
      init_seq(1'b0);

      // Word round trip and sub-word lanes
      xact(24'h000100, 1'b1, 32'hDEADBEEF, DW_WORD, 0);
      xact(24'h000100, 1'b0, 32'h0, DW_WORD, 0);
      check("word_rt", bus.read_data, 32'hDEADBEEF);
      xact(24'h000100, 1'b1, 32'h11223344, DW_WORD, 0);
      xact(24'h000103, 1'b1, 32'h0000005A, DW_BYTE, 0);
      xact(24'h000100, 1'b0, 32'h0, DW_WORD, 0);
      check("byte_merge", bus.read_data, 32'h5A223344);
      xact(24'h000102, 1'b0, 32'h0, DW_HALF, 0);
      check("half_load", bus.read_data, 32'h00005A22);
      xact(24'h000101, 1'b0, 32'h0, DW_BYTE, 0);
      check("byte_load", bus.read_data, 32'h00000033);
      check("model_half", model_load(24'h000102, DW_HALF), 32'h00005A22);
      check("model_byte", model_load(24'h000101, DW_BYTE), 32'h00000033);

      // Held enable: ready must stay high in DONE, then the next request is accepted
      xact(24'h000104, 1'b1, 32'h77665544, DW_WORD, 20);
      xact(24'h000104, 1'b0, 32'h0, 2'b11, 0);
      check("held_store", bus.read_data, 32'h77665544);

      // LATENCY=0 instance: two-cycle response and address aliasing
      for (int i = 0; i < 2000 && bus0.ready !== 1'b1; i++) @(negedge clk);
      check("l0_idle", {31'b0, bus0.ready}, 32'd1);
      bus0.enable = 1'b1; bus0.write = 1'b1; bus0.addr = 24'h000100;
      bus0.write_data = 32'h0BADCAFE; bus0.data_width = DW_WORD;
      @(posedge clk); #1 check("l0_st_e0", {31'b0, bus0.ready}, 32'd0);
      @(posedge clk); #1 check("l0_st_e1", {31'b0, bus0.ready}, 32'd0);
      @(posedge clk); #1 check("l0_st_e2", {31'b0, bus0.ready}, 32'd1);
      @(negedge clk); bus0.enable = 1'b0;
      @(posedge clk); @(negedge clk);
      bus0.enable = 1'b1; bus0.write = 1'b0; bus0.addr = 24'h001100;
      @(posedge clk); #1 check("l0_ld_e0", {31'b0, bus0.ready}, 32'd0);
      @(posedge clk); #1 check("l0_ld_e1", {31'b0, bus0.ready}, 32'd0);
      @(posedge clk); #1 check("l0_ld_e2", {31'b0, bus0.ready}, 32'd1);
      check("l0_alias", bus0.read_data, 32'h0BADCAFE);
      @(negedge clk); bus0.enable = 1'b0;
      @(posedge clk); @(negedge clk);

      // Randomized traffic over a 16-word window, upper address bits random
      for (int i = 0; i < 16; i++) xact(24'(i * 4), 1'b1, $urandom, DW_WORD, 0);
      for (int i = 0; i < 150; i++) begin
         xact({12'($urandom), 6'b0, 6'($urandom)}, 1'($urandom), $urandom,
              2'($urandom), int'($urandom_range(0, 3)));
      end

      // Reset during WAIT of a store aborts it
      xact(24'h000000, 1'b1, 32'h13579BDF, DW_WORD, 0);
      xact(24'h000100, 1'b0, 32'h0, DW_WORD, 0);
      bus.enable = 1'b1; bus.write = 1'b1; bus.addr = 24'h000000;
      bus.write_data = 32'hCAFEF00D; bus.data_width = DW_WORD;
      @(posedge clk); #1 exp_ready = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      exp_rd = '0;
      #1;
      check("rst_mid_ready", {31'b0, bus.ready}, 32'd0);
      check("rst_mid_rdata", bus.read_data, 32'd0);
      bus.enable = 1'b0;
      init_seq(1'b1);
      xact(24'h000000, 1'b0, 32'h0, DW_WORD, 0);
      check("aborted_store", bus.read_data, ZF ? 32'd0 : 32'h13579BDF);
      xact(24'h000100, 1'b0, 32'h0, DW_WORD, 0);
      check("init_ignores_en", bus.read_data, ZF ? 32'd0 : 32'h5A223344);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
